// File: rtl/bios_watchdog.sv
// BIOS boot watchdog: times host POST after each platform reset release and,
// on timeout, pulses a flash swap and requests a platform restart.
module bios_watchdog #(
    parameter int unsigned PRESCALE       = 33000,
    parameter int unsigned TIMEOUT_MS     = 5000,
    parameter int unsigned MAX_SWAPS      = 2,
    parameter int unsigned RESTART_CYCLES = 16
) (
    input  logic       LpcClock,
    input  logic       ResetN,
    input  logic       MainReset,
    input  logic       SwapDisable,
    input  logic       Write,
    input  logic [7:0] RegAddress,
    input  logic [7:0] DataWr,
    output logic [1:0] ForceSwap,
    output logic       RestartReq,
    output logic [7:0] WdtStatus
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] ARMED   = 3'd1;
    localparam logic [2:0] EXPIRED = 3'd2;
    localparam logic [2:0] RESTART = 3'd3;
    localparam logic [2:0] WAIT    = 3'd4;
    localparam logic [2:0] LOCKED  = 3'd5;

    localparam logic [7:0] CtlAddress = 8'h05;

    localparam int unsigned PreW = (PRESCALE > 1)       ? $clog2(PRESCALE)       : 1;
    localparam int unsigned MsW  = (TIMEOUT_MS > 1)     ? $clog2(TIMEOUT_MS)     : 1;
    localparam int unsigned RstW = (RESTART_CYCLES > 1) ? $clog2(RESTART_CYCLES) : 1;

    localparam logic [PreW-1:0] PreLast = PreW'(PRESCALE - 1);
    localparam logic [MsW-1:0]  MsLast  = MsW'(TIMEOUT_MS - 1);
    localparam logic [RstW-1:0] RstLast = RstW'(RESTART_CYCLES - 1);

    logic [2:0]      state;
    logic [2:0]      stateNxt;
    logic [1:0]      mainEdge;
    logic [PreW-1:0] preCnt;
    logic [PreW-1:0] preNxt;
    logic [MsW-1:0]  msCnt;
    logic [MsW-1:0]  msNxt;
    logic [RstW-1:0] rstCnt;
    logic [RstW-1:0] rstNxt;
    logic [1:0]      swapCnt;
    logic [1:0]      swapNxt;
    logic            expired;
    logic            expiredNxt;
    logic            timeoutHit;

    logic ctlWrite;
    logic ctlKick;
    logic ctlDisable;
    logic ctlSoftSwap;
    logic mainRise;
    logic mainFall;
    logic unusedDataBits;

    assign ctlWrite       = Write & (RegAddress == CtlAddress);
    assign ctlKick        = ctlWrite & DataWr[0];
    assign ctlDisable     = ctlWrite & DataWr[1];
    assign ctlSoftSwap    = ctlWrite & DataWr[2];
    assign unusedDataBits = ^DataWr[7:3];

    assign mainRise = (mainEdge == 2'b01);
    assign mainFall = (mainEdge == 2'b10);

    // Priority: MainReset fall, then Disable, then Kick, then expiry; LOCKED ignores all of them.
    always_comb begin
        stateNxt   = state;
        preNxt     = preCnt;
        msNxt      = msCnt;
        rstNxt     = rstCnt;
        swapNxt    = swapCnt;
        expiredNxt = expired;
        timeoutHit = 1'b0;

        if (state != LOCKED) begin
            if (mainFall) begin
                stateNxt = IDLE;
                preNxt   = '0;
                msNxt    = '0;
                rstNxt   = '0;
            end else if (ctlDisable) begin
                stateNxt   = IDLE;
                preNxt     = '0;
                msNxt      = '0;
                rstNxt     = '0;
                swapNxt    = '0;
                expiredNxt = 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (mainRise && !SwapDisable) begin
                            stateNxt = ARMED;
                            preNxt   = '0;
                            msNxt    = '0;
                        end
                    end

                    ARMED: begin
                        if (ctlKick) begin
                            preNxt = '0;
                            msNxt  = '0;
                        end else if (preCnt == PreLast) begin
                            preNxt = '0;
                            if (msCnt == MsLast) begin
                                stateNxt   = EXPIRED;
                                msNxt      = '0;
                                timeoutHit = 1'b1;
                            end else begin
                                msNxt = msCnt + 1'b1;
                            end
                        end else begin
                            preNxt = preCnt + 1'b1;
                        end
                    end

                    EXPIRED: begin
                        swapNxt    = (swapCnt == 2'd3) ? swapCnt : swapCnt + 2'd1;
                        expiredNxt = 1'b1;
                        if (32'(swapNxt) == MAX_SWAPS) begin
                            stateNxt = LOCKED;
                        end else begin
                            stateNxt = RESTART;
                            rstNxt   = '0;
                        end
                    end

                    RESTART: begin
                        if (rstCnt == RstLast) begin
                            stateNxt = WAIT;
                            rstNxt   = '0;
                        end else begin
                            rstNxt = rstCnt + 1'b1;
                        end
                    end

                    WAIT: begin
                        if (mainRise && !SwapDisable) begin
                            stateNxt = ARMED;
                            preNxt   = '0;
                            msNxt    = '0;
                        end
                    end

                    default: begin
                        stateNxt = IDLE;
                        preNxt   = '0;
                        msNxt    = '0;
                        rstNxt   = '0;
                    end
                endcase
            end
        end
    end

    // Edge history resets high so a MainReset already high at power-up is not seen as a rise.
    always_ff @(posedge LpcClock or negedge ResetN) begin
        if (!ResetN) begin
            mainEdge <= 2'b11;
        end else begin
            mainEdge <= {mainEdge[0], MainReset};
        end
    end

    always_ff @(posedge LpcClock or negedge ResetN) begin
        if (!ResetN) begin
            state   <= IDLE;
            preCnt  <= '0;
            msCnt   <= '0;
            rstCnt  <= '0;
            swapCnt <= '0;
            expired <= 1'b0;
        end else begin
            state   <= stateNxt;
            preCnt  <= preNxt;
            msCnt   <= msNxt;
            rstCnt  <= rstNxt;
            swapCnt <= swapNxt;
            expired <= expiredNxt;
        end
    end

    // Outputs are registered from next-state values so they line up with the state they describe.
    always_ff @(posedge LpcClock or negedge ResetN) begin
        if (!ResetN) begin
            ForceSwap  <= '0;
            RestartReq <= 1'b0;
            WdtStatus  <= '0;
        end else begin
            ForceSwap  <= {ctlSoftSwap & (state != LOCKED), timeoutHit};
            RestartReq <= (stateNxt == RESTART);
            WdtStatus  <= {stateNxt, swapNxt, expiredNxt,
                           (stateNxt == ARMED), (stateNxt == LOCKED)};
        end
    end

endmodule

// File: tb/tb_bios_watchdog.sv
// Self-checking bench for bios_watchdog: expected ForceSwap pulses (value and
// cycle) are queued when stimulus is driven and matched by a pulse monitor.
module tb_bios_watchdog;

    localparam int unsigned PRE  = 4;
    localparam int unsigned TMO  = 3;
    localparam int unsigned MAXS = 2;
    localparam int unsigned RCY  = 5;
    localparam int ExpLat = PRE * TMO;

    logic       LpcClock    = 1'b0;
    logic       ResetN      = 1'b0;
    logic       MainReset   = 1'b0;
    logic       SwapDisable = 1'b0;
    logic       Write       = 1'b0;
    logic [7:0] RegAddress  = 8'h00;
    logic [7:0] DataWr      = 8'h00;
    logic [1:0] ForceSwap;
    logic       RestartReq;
    logic [7:0] WdtStatus;

    typedef struct {
        logic [1:0] val;
        int         cyc;
    } pulse_t;

    pulse_t sb[$];
    int     total = 0;
    int     bad   = 0;
    int     cyc   = 0;
    bit     modelLocked = 1'b0;

    bios_watchdog #(
        .PRESCALE      (PRE),
        .TIMEOUT_MS    (TMO),
        .MAX_SWAPS     (MAXS),
        .RESTART_CYCLES(RCY)
    ) dut (
        .LpcClock   (LpcClock),
        .ResetN     (ResetN),
        .MainReset  (MainReset),
        .SwapDisable(SwapDisable),
        .Write      (Write),
        .RegAddress (RegAddress),
        .DataWr     (DataWr),
        .ForceSwap  (ForceSwap),
        .RestartReq (RestartReq),
        .WdtStatus  (WdtStatus)
    );

    always #5 LpcClock = ~LpcClock;

    always @(posedge LpcClock) cyc++;

    // Every nonzero ForceSwap sample must match the head of the scoreboard.
    always @(negedge LpcClock) begin : pulseMonitor
        pulse_t e;
        if (ForceSwap !== 2'b00) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL pulse_unexpected cyc=%0d got=%b want=none", cyc, ForceSwap);
            end else begin
                e = sb.pop_front();
                if (ForceSwap !== e.val || cyc != e.cyc) begin
                    bad++;
                    $display("FAIL pulse_match got=%b@%0d want=%b@%0d", ForceSwap, cyc, e.val, e.cyc);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout got=running want=finished");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge LpcClock);
    endtask

    task automatic toNeg(input int t);
        do @(negedge LpcClock); while (cyc < t);
    endtask

    // Called between edges; the write is sampled at the next rising edge (cycle cyc+1).
    task automatic wrReg(input logic [7:0] d);
        int s = cyc + 1;
        Write      = 1'b1;
        RegAddress = 8'h05;
        DataWr     = d;
        if (d[2] && !modelLocked) sb.push_back('{2'b10, s});
        @(posedge LpcClock);
        #1;
        Write  = 1'b0;
        DataWr = 8'h00;
    endtask

    task automatic applyReset();
        ResetN      = 1'b0;
        MainReset   = 1'b0;
        SwapDisable = 1'b0;
        Write       = 1'b0;
        modelLocked = 1'b0;
        tick(3);
        ResetN = 1'b1;
        tick(2);
    endtask

    task automatic waitArmed(output int a);
        int n = 0;
        a = -1;
        while (n < 10 && a < 0) begin
            @(negedge LpcClock);
            if (WdtStatus[1] === 1'b1) a = cyc;
            n++;
        end
        total++;
        if (a < 0) begin
            bad++;
            $display("FAIL arm_timeout got=not_armed want=armed_within_10");
        end
    endtask

    task automatic bootArm(output int a);
        MainReset = 1'b0;
        tick(3);
        MainReset = 1'b1;
        waitArmed(a);
    endtask

    task automatic drainCheck(input string name);
        tick(4);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL %s_pending got=%0d want=0 outstanding pulses", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        ResetN    = 1'b0;
        MainReset = 1'b0;
        tick(2);
        total++;
        if (ForceSwap !== 2'b00) begin bad++; $display("FAIL reset_forceswap got=%b want=00", ForceSwap); end
        total++;
        if (RestartReq !== 1'b0) begin bad++; $display("FAIL reset_restart got=%b want=0", RestartReq); end
        total++;
        if (WdtStatus !== 8'h00) begin bad++; $display("FAIL reset_status got=%h want=00", WdtStatus); end
        ResetN = 1'b1;
        tick(3);
        total++;
        if (WdtStatus !== 8'h00) begin bad++; $display("FAIL release_status got=%h want=00", WdtStatus); end
    endtask

    task automatic test_timeout();
        int   a;
        logic want;
        applyReset();
        bootArm(a);
        total++;
        if (WdtStatus !== 8'h22) begin bad++; $display("FAIL timeout_armed got=%h want=22", WdtStatus); end
        sb.push_back('{2'b01, a + ExpLat});
        for (int c = a + 1; c <= a + ExpLat + int'(RCY) + 2; c++) begin
            toNeg(c);
            want = (c >= a + ExpLat + 1) && (c <= a + ExpLat + int'(RCY));
            total++;
            if (RestartReq !== want) begin
                bad++;
                $display("FAIL timeout_restart cyc=%0d got=%b want=%b", c - a, RestartReq, want);
            end
            if (c == a + ExpLat + int'(RCY) + 1) begin
                total++;
                if (WdtStatus !== 8'h8C) begin bad++; $display("FAIL timeout_wait_status got=%h want=8C", WdtStatus); end
            end
        end
        drainCheck("timeout");
    endtask

    task automatic test_kick_disable();
        int a;
        applyReset();
        bootArm(a);
        sb.push_back('{2'b01, a + ExpLat});
        toNeg(a + ExpLat + int'(RCY) + 1);
        bootArm(a);
        total++;
        if (WdtStatus !== 8'h2E) begin bad++; $display("FAIL kick_rearm_status got=%h want=2E", WdtStatus); end
        for (int i = 0; i < 6; i++) begin
            wrReg(8'h01);
            tick(9);
        end
        total++;
        if (WdtStatus !== 8'h2E) begin bad++; $display("FAIL kick_still_armed got=%h want=2E", WdtStatus); end
        wrReg(8'h03);
        @(negedge LpcClock);
        total++;
        if (WdtStatus !== 8'h00) begin bad++; $display("FAIL disable_status got=%h want=00", WdtStatus); end
        tick(20);
        total++;
        if (WdtStatus !== 8'h00) begin bad++; $display("FAIL disable_hold got=%h want=00", WdtStatus); end
        drainCheck("kick_disable");
    endtask

    task automatic test_softswap();
        wrReg(8'h04);
        tick(2);
        total++;
        if (WdtStatus !== 8'h00) begin bad++; $display("FAIL softswap_state got=%h want=00", WdtStatus); end
        wrReg(8'h04);
        wrReg(8'h04);
        tick(2);
        total++;
        if (WdtStatus !== 8'h00) begin bad++; $display("FAIL softswap_b2b_state got=%h want=00", WdtStatus); end
        drainCheck("softswap");
    endtask

    task automatic test_lock();
        int a;
        applyReset();
        bootArm(a);
        sb.push_back('{2'b01, a + ExpLat});
        toNeg(a + ExpLat + int'(RCY) + 1);
        bootArm(a);
        sb.push_back('{2'b01, a + ExpLat});
        modelLocked = 1'b1;
        for (int c = a + ExpLat + 1; c <= a + ExpLat + 4; c++) begin
            toNeg(c);
            total++;
            if (RestartReq !== 1'b0) begin bad++; $display("FAIL lock_restart cyc=%0d got=%b want=0", c - a, RestartReq); end
        end
        total++;
        if (WdtStatus !== 8'hB5) begin bad++; $display("FAIL lock_status got=%h want=B5", WdtStatus); end
        wrReg(8'h04);
        tick(3);
        total++;
        if (WdtStatus !== 8'hB5) begin bad++; $display("FAIL lock_softswap_status got=%h want=B5", WdtStatus); end
        MainReset = 1'b0;
        tick(4);
        total++;
        if (WdtStatus !== 8'hB5) begin bad++; $display("FAIL lock_fall_status got=%h want=B5", WdtStatus); end
        drainCheck("lock");
    endtask

    task automatic test_collision();
        int a;
        applyReset();
        bootArm(a);
        toNeg(a + ExpLat - 1);
        wrReg(8'h01);
        @(negedge LpcClock);
        total++;
        if (WdtStatus !== 8'h22) begin bad++; $display("FAIL collision_kick_status got=%h want=22", WdtStatus); end
        sb.push_back('{2'b01, a + 2 * ExpLat});
        toNeg(a + 2 * ExpLat + int'(RCY) + 2);
        drainCheck("collision_kick");

        applyReset();
        bootArm(a);
        toNeg(a + ExpLat - 2);
        MainReset = 1'b0;
        toNeg(a + ExpLat);
        total++;
        if (WdtStatus !== 8'h00) begin bad++; $display("FAIL collision_fall_status got=%h want=00", WdtStatus); end
        tick(20);
        total++;
        if (WdtStatus !== 8'h00) begin bad++; $display("FAIL collision_fall_hold got=%h want=00", WdtStatus); end
        drainCheck("collision_fall");
    endtask

    task automatic test_swapdisable_reset();
        int a;
        applyReset();
        SwapDisable = 1'b1;
        tick(3);
        MainReset = 1'b1;
        tick(10);
        total++;
        if (WdtStatus !== 8'h00) begin bad++; $display("FAIL swapdisable_status got=%h want=00", WdtStatus); end
        SwapDisable = 1'b0;
        bootArm(a);
        toNeg(a + 6);
        total++;
        if (WdtStatus !== 8'h22) begin bad++; $display("FAIL midcount_status got=%h want=22", WdtStatus); end
        #2;
        ResetN = 1'b0;
        #1;
        total++;
        if (ForceSwap !== 2'b00) begin bad++; $display("FAIL async_forceswap got=%b want=00", ForceSwap); end
        total++;
        if (RestartReq !== 1'b0) begin bad++; $display("FAIL async_restart got=%b want=0", RestartReq); end
        total++;
        if (WdtStatus !== 8'h00) begin bad++; $display("FAIL async_status got=%h want=00", WdtStatus); end
        @(negedge LpcClock);
        ResetN = 1'b1;
        tick(30);
        total++;
        if (WdtStatus !== 8'h00) begin bad++; $display("FAIL noarm_after_reset got=%h want=00", WdtStatus); end
        drainCheck("swapdisable_reset");
    endtask

    initial begin
        test_reset();
        test_timeout();
        test_kick_disable();
        test_softswap();
        test_lock();
        test_collision();
        test_swapdisable_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
